branch_ctrl: RTL

- Consumer end of the fetch unit's instruction and branch-control interface.
- Takes the fetched 32-bit LEGv8 instruction and drives back imm19, imm26, un_br and br_taken so the fetch unit can select the next PC.
- Holds the architectural NZVC flag register, which is written by flag-setting ALU instructions.
- Runs a small squash FSM so that a pipelined fetch can discard the instruction fetched behind a taken branch.

---
 rtl/branch_ctrl.sv | 121 ++++++++++++
 1 files changed

// File: rtl/branch_ctrl.sv
// Branch-control consumer for the LEGv8 fetch unit: decode, NZVC flags, squash FSM.
// Optional taken-branch counter is built only when BR_STATS_EN is defined.
module branch_ctrl #(
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [31:0]      inst,
   input  logic             inst_valid,
   input  logic             alu_negative,
   input  logic             alu_zero,
   input  logic             alu_overflow,
   input  logic             alu_carry_out,
   input  logic             rt_zero,
   output logic [18:0]      imm19,
   output logic [25:0]      imm26,
   output logic             un_br,
   output logic             br_taken,
   output logic             flush,
   output logic             link_wr,
   output logic [3:0]       flags,
   output logic [CNT_W-1:0] br_count
);

   typedef enum logic {
      ST_RUN    = 1'b0,
      ST_SQUASH = 1'b1
   } state_t;

   state_t     r_state;
   logic [3:0] r_flags;

   logic w_is_b;
   logic w_is_bl;
   logic w_is_cbz;
   logic w_is_bcond;
   logic w_is_fs;
   logic w_accept;
   logic w_cond_true;
   logic w_br_taken;

   // Opcode decode
   assign w_is_b     = (inst[31:26] == 6'b000101);
   assign w_is_bl    = (inst[31:26] == 6'b100101);
   assign w_is_cbz   = (inst[31:24] == 8'b10110100);
   assign w_is_bcond = (inst[31:24] == 8'b01010100);
   assign w_is_fs    = (inst[31:21] == 11'b10101011000) ||
                       (inst[31:21] == 11'b11101011000) ||
                       (inst[31:21] == 11'b11101010000) ||
                       (inst[31:22] == 10'b1011000100)  ||
                       (inst[31:22] == 10'b1111000100);

   assign w_accept = inst_valid && (r_state == ST_RUN) && !reset;

   // Condition evaluation from registered flags {N,Z,C,V}
   always_comb begin
      w_cond_true = 1'b1;
      case (inst[3:0])
         4'd0:    w_cond_true = r_flags[2];
         4'd1:    w_cond_true = !r_flags[2];
         4'd2:    w_cond_true = r_flags[1];
         4'd3:    w_cond_true = !r_flags[1];
         4'd4:    w_cond_true = r_flags[3];
         4'd5:    w_cond_true = !r_flags[3];
         4'd6:    w_cond_true = r_flags[0];
         4'd7:    w_cond_true = !r_flags[0];
         4'd8:    w_cond_true = r_flags[1] && !r_flags[2];
         4'd9:    w_cond_true = !(r_flags[1] && !r_flags[2]);
         4'd10:   w_cond_true = (r_flags[3] == r_flags[0]);
         4'd11:   w_cond_true = (r_flags[3] != r_flags[0]);
         4'd12:   w_cond_true = !r_flags[2] && (r_flags[3] == r_flags[0]);
         4'd13:   w_cond_true = !(!r_flags[2] && (r_flags[3] == r_flags[0]));
         default: w_cond_true = 1'b1;
      endcase
   end

   assign w_br_taken = w_accept && (w_is_b || w_is_bl ||
                                    (w_is_cbz && rt_zero) ||
                                    (w_is_bcond && w_cond_true));

   assign imm19    = inst[23:5];
   assign imm26    = inst[25:0];
   assign un_br    = w_accept && (w_is_b || w_is_bl);
   assign br_taken = w_br_taken;
   assign link_wr  = w_accept && w_is_bl;
   assign flush    = (r_state == ST_SQUASH) && !reset;
   assign flags    = r_flags;

   // Squash FSM and flag register
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= ST_RUN;
         r_flags <= 4'b0000;
      end else begin
         case (r_state)
            ST_RUN:    if (w_br_taken) r_state <= ST_SQUASH;
            ST_SQUASH: r_state <= ST_RUN;
            default:   r_state <= ST_RUN;
         endcase
         if (w_accept && w_is_fs)
            r_flags <= {alu_negative, alu_zero, alu_carry_out, alu_overflow};
      end
   end

`ifdef BR_STATS_EN
   logic [CNT_W-1:0] r_br_count;

   // Saturating taken-branch counter
   always_ff @(posedge clk) begin
      if (reset)
         r_br_count <= '0;
      else if (w_br_taken && (r_br_count != {CNT_W{1'b1}}))
         r_br_count <= r_br_count + CNT_W'(1);
   end

   assign br_count = r_br_count;
`else
   assign br_count = '0;
`endif

endmodule
